// File: rtl/muldiv_share_ctrl_if.sv
// Requester-side bundle for muldiv_share_ctrl.
// Two requesters, operand buses packed as {req1, req0}.
//   req_valid_i/req_div_i   per-requester request and div/mult select
//   req_op1_i/req_op2_i     {req1 op, req0 op}, 32 bits each
//   req_ready_o             one-hot accept pulse
//   resp_valid_o            one-hot result valid for the owner
//   resp_ready_i            per-requester result consume
//   resp_hi_o/resp_lo_o     shared 64-bit result
interface muldiv_share_ctrl_if;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_div_i;
   logic [63:0] req_op1_i;
   logic [63:0] req_op2_i;
   logic [1:0]  req_ready_o;
   logic [1:0]  resp_valid_o;
   logic [1:0]  resp_ready_i;
   logic [31:0] resp_hi_o;
   logic [31:0] resp_lo_o;

   modport master (
      output req_valid_i,
      output req_div_i,
      output req_op1_i,
      output req_op2_i,
      output resp_ready_i,
      input  req_ready_o,
      input  resp_valid_o,
      input  resp_hi_o,
      input  resp_lo_o
   );

   modport slave (
      input  req_valid_i,
      input  req_div_i,
      input  req_op1_i,
      input  req_op2_i,
      input  resp_ready_i,
      output req_ready_o,
      output resp_valid_o,
      output resp_hi_o,
      output resp_lo_o
   );
endinterface

// File: rtl/muldiv_share_ctrl.sv
// Shares one multi-cycle signed mul/div unit between two requesters.
// Round-robin grant, then START, BUSY, DRAIN, read LO, read HI, respond.
//   clk_i, rst_ni      clock, async active-low reset
//   req_if (slave)     requester request/response bundle
//   md_ctl_o           unit command: nop/MULT/DIV/MFLO/MFHI
//   md_op1_o/md_op2_o  latched operands to the unit
//   md_res_i           unit read data, valid with MFLO/MFHI
//   md_stall_i         unit busy
//   busy_o             controller not idle
module muldiv_share_ctrl #(
   parameter int unsigned DRAIN_CYC = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   muldiv_share_ctrl_if.slave       req_if,
   output logic [3:0]               md_ctl_o,
   output logic [31:0]              md_op1_o,
   output logic [31:0]              md_op2_o,
   input  logic [31:0]              md_res_i,
   input  logic                     md_stall_i,
   output logic                     busy_o
);

   localparam logic [3:0] CTL_NOP  = 4'b0000;
   localparam logic [3:0] CTL_MULT = 4'b1100;
   localparam logic [3:0] CTL_DIV  = 4'b1110;
   localparam logic [3:0] CTL_MFLO = 4'b1010;
   localparam logic [3:0] CTL_MFHI = 4'b1000;

   localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_DRAIN,
      S_RD_LO,
      S_RD_HI,
      S_RESP
   } state_e;

   state_e      state_q;
   logic        rr_q;
   logic        quiet_q;
   logic        own_q;
   logic [31:0] op1_q;
   logic [31:0] op2_q;
   logic [2:0]  cnt_q;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic [3:0]  ctl_q;
   logic [1:0]  rvld_q;
   logic        busy_q;

   logic [1:0]  rv;
   logic        gidx;
   logic        gnt;
   logic        g_div;
   logic [31:0] g_op1;
   logic [31:0] g_op2;

   assign rv = req_if.req_valid_i;

   // Both valid: rr_q picks. Otherwise the single valid one wins.
   assign gidx = rv[1] & (~rv[0] | rr_q);

   // Unit must have been quiet for this and the previous cycle.
   assign gnt = (state_q == S_IDLE) & quiet_q & ~md_stall_i & (|rv);

   always_comb begin
      g_div = req_if.req_div_i[0];
      g_op1 = req_if.req_op1_i[31:0];
      g_op2 = req_if.req_op2_i[31:0];
      if (gidx) begin
         g_div = req_if.req_div_i[1];
         g_op1 = req_if.req_op1_i[63:32];
         g_op2 = req_if.req_op2_i[63:32];
      end
   end

   // Accept is combinational so it lands in the IDLE cycle itself.
   assign req_if.req_ready_o = gnt ? (gidx ? 2'b10 : 2'b01) : 2'b00;

   assign req_if.resp_valid_o = rvld_q;
   assign req_if.resp_hi_o    = hi_q;
   assign req_if.resp_lo_o    = lo_q;

   assign md_ctl_o = ctl_q;
   assign md_op1_o = op1_q;
   assign md_op2_o = op2_q;
   assign busy_o   = busy_q;

   // ctl_q, rvld_q and busy_q are set on entry to the state that
   // owns them so every output comes straight from a flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rr_q    <= 1'b0;
         quiet_q <= 1'b0;
         own_q   <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         ctl_q   <= CTL_NOP;
         rvld_q  <= 2'b00;
         busy_q  <= 1'b0;
      end else begin
         quiet_q <= ~md_stall_i;
         ctl_q   <= CTL_NOP;
         unique case (state_q)
            S_IDLE: begin
               if (gnt) begin
                  own_q   <= gidx;
                  op1_q   <= g_op1;
                  op2_q   <= g_op2;
                  rr_q    <= ~gidx;
                  ctl_q   <= g_div ? CTL_DIV : CTL_MULT;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               state_q <= S_BUSY;
            end
            S_BUSY: begin
               if (!md_stall_i) begin
                  cnt_q   <= DRAIN_LD;
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (cnt_q == 3'd0) begin
                  ctl_q   <= CTL_MFLO;
                  state_q <= S_RD_LO;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_RD_LO: begin
               lo_q    <= md_res_i;
               ctl_q   <= CTL_MFHI;
               state_q <= S_RD_HI;
            end
            S_RD_HI: begin
               hi_q    <= md_res_i;
               rvld_q  <= own_q ? 2'b10 : 2'b01;
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (req_if.resp_ready_i[own_q]) begin
                  rvld_q  <= 2'b00;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_share_ctrl.sv
// Directed bench for muldiv_share_ctrl.
// Two DUTs (DRAIN_CYC 2 and 1) run the same stimulus on private unit models.
module tb_muldiv_share_ctrl;

   localparam logic [3:0] C_MULT = 4'b1100;
   localparam logic [3:0] C_DIV  = 4'b1110;
   localparam logic [3:0] C_MFLO = 4'b1010;
   localparam logic [3:0] C_MFHI = 4'b1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_share_ctrl_if ifa ();
   muldiv_share_ctrl_if ifb ();

   assign ifb.req_valid_i  = ifa.req_valid_i;
   assign ifb.req_div_i    = ifa.req_div_i;
   assign ifb.req_op1_i    = ifa.req_op1_i;
   assign ifb.req_op2_i    = ifa.req_op2_i;
   assign ifb.resp_ready_i = ifa.resp_ready_i;

   logic [3:0]  ctl_a, ctl_b;
   logic [31:0] op1_a, op2_a, op1_b, op2_b;
   logic [31:0] res_a, res_b;
   logic        stall_a, stall_b, busy_a, busy_b;

   muldiv_share_ctrl #(.DRAIN_CYC(2)) dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_if     (ifa.slave),
      .md_ctl_o   (ctl_a),
      .md_op1_o   (op1_a),
      .md_op2_o   (op2_a),
      .md_res_i   (res_a),
      .md_stall_i (stall_a),
      .busy_o     (busy_a)
   );

   muldiv_share_ctrl #(.DRAIN_CYC(1)) dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_if     (ifb.slave),
      .md_ctl_o   (ctl_b),
      .md_op1_o   (op1_b),
      .md_op2_o   (op2_b),
      .md_res_i   (res_b),
      .md_stall_i (stall_b),
      .busy_o     (busy_b)
   );

   // Mul/div unit models, index 0 -> dut_a, 1 -> dut_b
   logic [3:0]  m_ctl [2];
   logic [31:0] m_a   [2];
   logic [31:0] m_b   [2];
   logic [31:0] m_hi  [2] = '{32'd0, 32'd0};
   logic [31:0] m_lo  [2] = '{32'd0, 32'd0};
   int          m_cnt [2] = '{0, 0};
   int          stall_len = 3;
   logic [63:0] mp;
   logic signed [31:0] msa, msb;

   assign m_ctl[0] = ctl_a;
   assign m_ctl[1] = ctl_b;
   assign m_a[0]   = op1_a;
   assign m_a[1]   = op1_b;
   assign m_b[0]   = op2_a;
   assign m_b[1]   = op2_b;
   assign stall_a  = (m_cnt[0] != 0);
   assign stall_b  = (m_cnt[1] != 0);
   assign res_a = (ctl_a == C_MFLO) ? m_lo[0] :
                  (ctl_a == C_MFHI) ? m_hi[0] : 32'd0;
   assign res_b = (ctl_b == C_MFLO) ? m_lo[1] :
                  (ctl_b == C_MFHI) ? m_hi[1] : 32'd0;

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (m_cnt[u] > 0) m_cnt[u] <= m_cnt[u] - 1;
         msa = m_a[u];
         msb = m_b[u];
         if (m_ctl[u] == C_MULT) begin
            mp = {{32{msa[31]}}, msa} * {{32{msb[31]}}, msb};
            m_hi[u]  <= mp[63:32];
            m_lo[u]  <= mp[31:0];
            m_cnt[u] <= stall_len;
         end else if (m_ctl[u] == C_DIV) begin
            if (msb != 0) begin
               m_lo[u] <= msa / msb;
               m_hi[u] <= msa % msb;
            end else begin
               m_lo[u] <= '1;
               m_hi[u] <= msa;
            end
            m_cnt[u] <= stall_len;
         end
      end
   end

   // ctl-code occupancy and dut_b timing monitors
   int n_lo_a = 0, n_hi_a = 0, n_lo_b = 0, n_hi_b = 0;
   int gb_cyc = -1, rb_cyc = -1;
   bit pv_b = 1'b0;
   always @(negedge clk) begin
      if (ctl_a == C_MFLO) n_lo_a++;
      if (ctl_a == C_MFHI) n_hi_a++;
      if (ctl_b == C_MFLO) n_lo_b++;
      if (ctl_b == C_MFHI) n_hi_b++;
      if (ifb.req_ready_o != 2'b00) gb_cyc = cyc;
      if (ifb.resp_valid_o != 2'b00 && !pv_b) rb_cyc = cyc;
      pv_b = (ifb.resp_valid_o != 2'b00);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic dv,
                          input logic [31:0] a, input logic [31:0] b);
      ifa.req_div_i[r]        = dv;
      ifa.req_op1_i[r*32 +: 32] = a;
      ifa.req_op2_i[r*32 +: 32] = b;
   endtask

   task automatic wait_gnt(input string tag, input logic [1:0] exp,
                           output int gc);
      gc = -1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ifa.req_ready_o != 2'b00) begin
            gc = cyc;
            break;
         end
      end
      chk(tag, 64'(ifa.req_ready_o), 64'(exp));
   endtask

   task automatic wait_resp(input string tag, input logic [1:0] exp,
                            output int rc);
      rc = -1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ifa.resp_valid_o != 2'b00) begin
            rc = cyc;
            break;
         end
      end
      chk(tag, 64'(ifa.resp_valid_o), 64'(exp));
   endtask

   task automatic ack_resp(input int g);
      @(posedge clk); #1;
      ifa.resp_ready_i = (g == 1) ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      ifa.resp_ready_i = 2'b00;
   endtask

   logic [31:0] t_a  [2][2];
   logic [31:0] t_b  [2][2];
   logic [31:0] t_hi [2][2];
   logic [31:0] t_lo [2][2];
   int idx [2];

   int gc, rc, g, lc, la, ra, snap_la, snap_ha, snap_lb, snap_hb;
   bit saw_vld;

   initial begin
      ifa.req_valid_i  = 2'b00;
      ifa.req_div_i    = 2'b00;
      ifa.req_op1_i    = '0;
      ifa.req_op2_i    = '0;
      ifa.resp_ready_i = 2'b00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst resp_valid", 64'(ifa.resp_valid_o), 64'd0);
      chk("rst req_ready", 64'(ifa.req_ready_o), 64'd0);
      chk("rst busy", 64'(busy_a), 64'd0);
      chk("rst ctl", 64'(ctl_a), 64'd0);
      chk("rst ops", {op1_a, op2_a}, 64'd0);
      chk("rst res", {ifa.resp_hi_o, ifa.resp_lo_o}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: req0 MULT 7 * -3
      set_req(0, 1'b0, 32'd7, 32'hFFFFFFFD);
      ifa.req_valid_i = 2'b01;
      wait_gnt("t1 rdy", 2'b01, gc);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b00;
      @(negedge clk);
      chk("t1 rdy pulse", 64'(ifa.req_ready_o), 64'd0);
      chk("t1 start ctl", 64'(ctl_a), 64'(C_MULT));
      chk("t1 ops", {op1_a, op2_a}, {32'd7, 32'hFFFFFFFD});
      chk("t1 busy", 64'(busy_a), 64'd1);
      wait_resp("t1 vld", 2'b01, rc);
      chk("t1 hi", 64'(ifa.resp_hi_o), 64'hFFFFFFFF);
      chk("t1 lo", 64'(ifa.resp_lo_o), 64'hFFFFFFEB);
      ack_resp(0);

      // 2: req1 DIV 100 / 7
      set_req(1, 1'b1, 32'd100, 32'd7);
      ifa.req_valid_i = 2'b10;
      wait_gnt("t2 rdy", 2'b10, gc);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b00;
      @(negedge clk);
      chk("t2 start ctl", 64'(ctl_a), 64'(C_DIV));
      wait_resp("t2 vld", 2'b10, rc);
      chk("t2 lo", 64'(ifa.resp_lo_o), 64'd14);
      chk("t2 hi", 64'(ifa.resp_hi_o), 64'd2);
      ack_resp(1);
      @(negedge clk);
      chk("t2 busy after ack", 64'(busy_a), 64'd0);

      // 3: both valid from reset, alternating grants
      t_a[0][0] = 32'd6;        t_b[0][0] = 32'd7;
      t_hi[0][0] = 32'd0;       t_lo[0][0] = 32'd42;
      t_a[0][1] = 32'h10000;    t_b[0][1] = 32'h10000;
      t_hi[0][1] = 32'd1;       t_lo[0][1] = 32'd0;
      t_a[1][0] = 32'hFFFFFFEC; t_b[1][0] = 32'd3;
      t_hi[1][0] = 32'hFFFFFFFE; t_lo[1][0] = 32'hFFFFFFFA;
      t_a[1][1] = 32'd1000;     t_b[1][1] = 32'hFFFFFFF6;
      t_hi[1][1] = 32'd0;       t_lo[1][1] = 32'hFFFFFF9C;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idx[0] = 0;
      idx[1] = 0;
      set_req(0, 1'b0, t_a[0][0], t_b[0][0]);
      set_req(1, 1'b1, t_a[1][0], t_b[1][0]);
      ifa.req_valid_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         g = k % 2;
         wait_gnt($sformatf("t3 rdy %0d", k),
                  (g == 1) ? 2'b10 : 2'b01, gc);
         @(posedge clk); #1;
         idx[g]++;
         if (idx[g] == 2) ifa.req_valid_i[g] = 1'b0;
         else set_req(g, g[0], t_a[g][idx[g]], t_b[g][idx[g]]);
         wait_resp($sformatf("t3 vld %0d", k),
                   (g == 1) ? 2'b10 : 2'b01, rc);
         chk($sformatf("t3 res %0d", k),
             {ifa.resp_hi_o, ifa.resp_lo_o},
             {t_hi[g][idx[g]-1], t_lo[g][idx[g]-1]});
         ack_resp(g);
      end

      // 4: owner stalls response while req1 waits
      set_req(0, 1'b0, 32'd7, 32'hFFFFFFFD);
      set_req(1, 1'b1, 32'd100, 32'd7);
      ifa.req_valid_i = 2'b11;
      wait_gnt("t4 rdy0", 2'b01, gc);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b10;
      wait_resp("t4 vld0", 2'b01, rc);
      @(posedge clk); #1;
      ifa.resp_ready_i = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t4 hold vld %0d", i),
             64'(ifa.resp_valid_o), 64'd1);
         chk($sformatf("t4 hold res %0d", i),
             {ifa.resp_hi_o, ifa.resp_lo_o}, 64'hFFFFFFFF_FFFFFFEB);
         chk($sformatf("t4 hold rdy %0d", i),
             64'(ifa.req_ready_o), 64'd0);
      end
      ack_resp(0);
      wait_gnt("t4 rdy1", 2'b10, gc);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b00;
      wait_resp("t4 vld1", 2'b10, rc);
      chk("t4 res1", {ifa.resp_hi_o, ifa.resp_lo_o}, {32'd2, 32'd14});
      ack_resp(1);

      // 5: reset while BUSY, then quiet gate
      stall_len = 8;
      set_req(0, 1'b0, 32'd7, 32'hFFFFFFFD);
      ifa.req_valid_i = 2'b01;
      wait_gnt("t5 rdy", 2'b01, gc);
      repeat (3) @(negedge clk);
      chk("t5 in busy", {63'd0, busy_a & stall_a}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5 rst ctl", 64'(ctl_a), 64'd0);
      chk("t5 rst ops", {op1_a, op2_a}, 64'd0);
      chk("t5 rst busy", 64'(busy_a), 64'd0);
      chk("t5 rst vld", 64'(ifa.resp_valid_o), 64'd0);
      chk("t5 rst rdy", 64'(ifa.req_ready_o), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lc = -1;
      gc = -1;
      saw_vld = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ifa.resp_valid_o != 2'b00) saw_vld = 1'b1;
         if (!stall_a && lc < 0) lc = cyc;
         if (stall_a) lc = -1;
         if (ifa.req_ready_o != 2'b00) begin
            gc = cyc;
            break;
         end
      end
      chk("t5 no resp", 64'(saw_vld), 64'd0);
      chk("t5 regrant", 64'(ifa.req_ready_o), 64'd1);
      chk("t5 quiet gap", 64'(gc - lc), 64'd1);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b00;
      wait_resp("t5 vld", 2'b01, rc);
      chk("t5 lo", 64'(ifa.resp_lo_o), 64'hFFFFFFEB);
      ack_resp(0);
      stall_len = 3;

      // 6: DRAIN_CYC 2 (dut_a) vs 1 (dut_b), same MULT
      snap_la = n_lo_a;
      snap_ha = n_hi_a;
      snap_lb = n_lo_b;
      snap_hb = n_hi_b;
      set_req(0, 1'b0, 32'h12345, 32'h100);
      ifa.req_valid_i = 2'b01;
      wait_gnt("t6 rdy", 2'b01, gc);
      @(posedge clk); #1;
      ifa.req_valid_i = 2'b00;
      wait_resp("t6 vld", 2'b01, rc);
      la = rc - gc;
      ra = rb_cyc - gb_cyc;
      chk("t6 latency delta", 64'(la - ra), 64'd1);
      chk("t6 res a", {ifa.resp_hi_o, ifa.resp_lo_o}, 64'h01234500);
      chk("t6 res b", {ifb.resp_hi_o, ifb.resp_lo_o}, 64'h01234500);
      ack_resp(0);
      @(negedge clk);
      chk("t6 mflo a", 64'(n_lo_a - snap_la), 64'd1);
      chk("t6 mfhi a", 64'(n_hi_a - snap_ha), 64'd1);
      chk("t6 mflo b", 64'(n_lo_b - snap_lb), 64'd1);
      chk("t6 mfhi b", 64'(n_hi_b - snap_hb), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule
